// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace monitor: state encoding, trace record layout, default reset PC.
package commit_trace_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } state_e;

    // 97-bit retirement record as queued in the trace FIFO.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        redirect;
        logic [31:0] seq;
    } trace_rec_t;

    localparam logic [31:0] DefaultResetPc = 32'h8000_0000;

endpackage

// File: rtl/commit_trace_fifo.sv
// Registered synchronous FIFO of trace records; no fall-through, pointers carry one extra wrap bit.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  trace_rec_t wdata_i,
    output trace_rec_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0] wr_ptr_q;
    logic [PtrW:0] rd_ptr_q;
    trace_rec_t    mem_q [Depth];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/commit_trace_monitor.sv
// Retirement-trace monitor: PC-flow tracking, instret, hang/overflow detection, buffered trace port.
// Optional perf counters (cycles_o, redirects_o) are built only with COMMIT_TRACE_PERF_EN defined.
module commit_trace_monitor
    import commit_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HANG_LIMIT = 1024,
    parameter logic [31:0] RESET_PC   = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_i,
    input  logic [31:0] commit_pc_i,
    input  logic [31:0] commit_pre_pc_i,
    input  logic        trace_ready_i,
    output logic        trace_valid_o,
    output logic [31:0] trace_pc_o,
    output logic [31:0] trace_next_pc_o,
    output logic        trace_redirect_o,
    output logic [31:0] trace_seq_o,
    output logic [63:0] instret_o,
    output logic [1:0]  state_o,
    output logic        hang_o,
    output logic        overflow_o,
    output logic        start_err_o,
    output logic [63:0] cycles_o,
    output logic [31:0] redirects_o
);

    localparam int unsigned IdleW = $clog2(HANG_LIMIT + 1);

    state_e           state_q, state_d;
    logic [31:0]      exp_pc_q, exp_pc_d;
    logic [63:0]      instret_q, instret_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             hang_q, hang_d;
    logic             ovf_q, ovf_d;
    logic             start_err_q, start_err_d;

    logic       redirect;
    logic       push_req;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    trace_rec_t push_rec;
    trace_rec_t head_rec;

    assign redirect = (commit_pc_i != exp_pc_q);
    assign pop      = !fifo_empty && trace_ready_i;
    assign push_req = commit_i && (state_q != StErr);
    assign push_rec = '{pc: commit_pc_i, next_pc: commit_pre_pc_i, redirect: redirect,
                        seq: instret_q[31:0]};

    always_comb begin
        state_d     = state_q;
        exp_pc_d    = exp_pc_q;
        instret_d   = instret_q;
        idle_d      = idle_q;
        hang_d      = hang_q;
        ovf_d       = ovf_q;
        start_err_d = start_err_q;

        if (commit_i)  instret_d = instret_q + 64'd1;
        if (push_req)  exp_pc_d  = commit_pre_pc_i;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (commit_i) begin
                    if (redirect) begin
                        start_err_d = 1'b1;
                        state_d     = StErr;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (commit_i) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                    if (idle_d == IdleW'(HANG_LIMIT)) begin
                        hang_d  = 1'b1;
                        state_d = StErr;
                    end
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            exp_pc_q    <= RESET_PC;
            instret_q   <= '0;
            idle_q      <= '0;
            hang_q      <= 1'b0;
            ovf_q       <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_pc_q    <= exp_pc_d;
            instret_q   <= instret_d;
            idle_q      <= idle_d;
            hang_q      <= hang_d;
            ovf_q       <= ovf_d;
            start_err_q <= start_err_d;
        end
    end

    commit_trace_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i (push_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign trace_valid_o    = !fifo_empty;
    assign trace_pc_o       = head_rec.pc;
    assign trace_next_pc_o  = head_rec.next_pc;
    assign trace_redirect_o = head_rec.redirect;
    assign trace_seq_o      = head_rec.seq;
    assign instret_o        = instret_q;
    assign state_o          = state_q;
    assign hang_o           = hang_q;
    assign overflow_o       = ovf_q;
    assign start_err_o      = start_err_q;

`ifdef COMMIT_TRACE_PERF_EN
    logic [63:0] cycles_q;
    logic [31:0] redirects_q;
    logic        count_redirect;

    assign count_redirect = commit_i && (state_q == StRun) && redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q    <= '0;
            redirects_q <= '0;
        end else begin
            if (state_q == StRun) cycles_q    <= cycles_q + 64'd1;
            if (count_redirect)   redirects_q <= redirects_q + 32'd1;
        end
    end

    assign cycles_o    = cycles_q;
    assign redirects_o = redirects_q;
`else
    assign cycles_o    = '0;
    assign redirects_o = '0;
`endif

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_commit_trace_monitor;

    localparam int          Depth     = 8;
    localparam int          HangLimit = 1024;
    localparam logic [31:0] ResetPc   = 32'h8000_0000;
`ifdef COMMIT_TRACE_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] cpc = '0;
    logic [31:0] cpre = '0;
    logic        ready = 1'b0;

    logic        trace_valid_o, trace_redirect_o, hang_o, overflow_o, start_err_o;
    logic [31:0] trace_pc_o, trace_next_pc_o, trace_seq_o, redirects_o;
    logic [63:0] instret_o, cycles_o;
    logic [1:0]  state_o;

    commit_trace_monitor #(
        .FIFO_DEPTH (Depth),
        .HANG_LIMIT (HangLimit),
        .RESET_PC   (ResetPc)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_i         (commit),
        .commit_pc_i      (cpc),
        .commit_pre_pc_i  (cpre),
        .trace_ready_i    (ready),
        .trace_valid_o    (trace_valid_o),
        .trace_pc_o       (trace_pc_o),
        .trace_next_pc_o  (trace_next_pc_o),
        .trace_redirect_o (trace_redirect_o),
        .trace_seq_o      (trace_seq_o),
        .instret_o        (instret_o),
        .state_o          (state_o),
        .hang_o           (hang_o),
        .overflow_o       (overflow_o),
        .start_err_o      (start_err_o),
        .cycles_o         (cycles_o),
        .redirects_o      (redirects_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        redir;
        logic [31:0] seq;
    } rec_t;

    // Reference model: 0=IDLE 1=RUN 2=ERR
    rec_t            mq[$];
    longint unsigned m_instret;
    longint unsigned m_cycles;
    logic [31:0]     m_redirects;
    int              m_state;
    logic [31:0]     m_exp;
    int              m_idle;
    bit              m_hang, m_ovf, m_serr;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_instret = 0; m_cycles = 0; m_redirects = '0; m_state = 0;
        m_exp = ResetPc; m_idle = 0; m_hang = 0; m_ovf = 0; m_serr = 0;
    endtask

    task automatic model_update(input bit c, input logic [31:0] pc, input logic [31:0] pre,
                                input bit r, input bit rs);
        int          st;
        int          sz;
        bit          popped;
        bit          rd;
        logic [31:0] seq;
        rec_t        rec;
        if (!rs) begin
            model_reset();
        end else begin
            st     = m_state;
            sz     = mq.size();
            popped = (sz > 0) && r;
            if (popped) void'(mq.pop_front());
            if (c) begin
                seq = m_instret[31:0];
                m_instret++;
                if (st != 2) begin
                    rd    = (pc != m_exp);
                    m_exp = pre;
                    if (st == 1 && rd) m_redirects++;
                    if (sz == Depth && !popped) begin
                        m_ovf = 1;
                    end else begin
                        rec.pc = pc; rec.npc = pre; rec.redir = rd; rec.seq = seq;
                        mq.push_back(rec);
                    end
                    if (st == 0) begin
                        if (rd) begin m_serr = 1; m_state = 2; end
                        else m_state = 1;
                    end
                end
            end
            if (st == 1) begin
                m_cycles++;
                if (c) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == HangLimit) begin m_hang = 1; m_state = 2; end
                end
            end
        end
    endtask

    task automatic step(input bit c, input logic [31:0] pc, input logic [31:0] pre,
                        input bit r, input bit rs = 1'b1);
        commit = c; cpc = pc; cpre = pre; ready = r; rst = rs;
        @(posedge clk);
        model_update(c, pc, pre, r, rs);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", trace_valid_o, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("pc", trace_pc_o, mq[0].pc);
                chk("next_pc", trace_next_pc_o, mq[0].npc);
                chk("redirect", trace_redirect_o, mq[0].redir);
                chk("seq", trace_seq_o, mq[0].seq);
            end
            chk("instret", instret_o, m_instret);
            chk("state", state_o, m_state);
            chk("hang", hang_o, m_hang);
            chk("overflow", overflow_o, m_ovf);
            chk("start_err", start_err_o, m_serr);
            chk("cycles", cycles_o, PerfEn ? m_cycles : 64'd0);
            chk("redirects", redirects_o, PerfEn ? m_redirects : 32'd0);
        end
    end

    task automatic do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          c, r, rs;
        logic [31:0] pc, pre;
        int          cp, rp;

        do_reset();
        cmp_en = 1'b1;
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_state", state_o, 0);

        // Three sequential commits with ready high
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ResetPc + 32'(4 * i), ResetPc + 32'(4 * i + 4), 1'b1);
            chk("seq_valid", trace_valid_o, 1);
            chk("seq_pc", trace_pc_o, ResetPc + 32'(4 * i));
            chk("seq_seq", trace_seq_o, i);
            chk("seq_redir", trace_redirect_o, 0);
        end
        step(1'b0, '0, '0, 1'b1);
        chk("seq_instret", instret_o, 3);
        chk("seq_state", state_o, 1);
        chk("seq_drained", trace_valid_o, 0);

        // Redirected second commit
        do_reset();
        step(1'b1, 32'h8000_0000, 32'h8000_0004, 1'b0);
        step(1'b1, 32'h8000_0100, 32'h8000_0104, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("redir_flag", trace_redirect_o, 1);
        chk("redir_pc", trace_pc_o, 32'h8000_0100);
        chk("redir_count", redirects_o, PerfEn ? 32'd1 : 32'd0);

        // Overflow: Depth+2 commits with ready low
        do_reset();
        for (int i = 0; i < Depth + 2; i++)
            step(1'b1, ResetPc + 32'(4 * i), ResetPc + 32'(4 * i + 4), 1'b0);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_instret", instret_o, 10);
        chk("ovf_state", state_o, 1);
        for (int i = 0; i < Depth; i++) begin
            chk("ovf_drain_seq", trace_seq_o, i);
            step(1'b0, '0, '0, 1'b1);
        end
        chk("ovf_empty", trace_valid_o, 0);

        // Bad start PC
        do_reset();
        step(1'b1, 32'h0, 32'h4, 1'b0);
        chk("serr_flag", start_err_o, 1);
        chk("serr_state", state_o, 2);
        chk("serr_valid", trace_valid_o, 1);
        chk("serr_pc", trace_pc_o, 0);

        // Hang detection
        do_reset();
        step(1'b1, ResetPc, ResetPc + 32'd4, 1'b1);
        for (int i = 0; i < HangLimit - 1; i++) step(1'b0, '0, '0, 1'b1);
        chk("hang_early", hang_o, 0);
        chk("hang_early_state", state_o, 1);
        step(1'b0, '0, '0, 1'b1);
        chk("hang_flag", hang_o, 1);
        chk("hang_state", state_o, 2);
        step(1'b1, ResetPc + 32'd4, ResetPc + 32'd8, 1'b1);
        chk("hang_instret", instret_o, 2);
        chk("hang_no_enq", trace_valid_o, 0);

        // Reset while records are queued
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, ResetPc + 32'(4 * i), ResetPc + 32'(4 * i + 4), 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("mid_rst_valid", trace_valid_o, 0);
        chk("mid_rst_instret", instret_o, 0);
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_flags", {hang_o, overflow_o, start_err_o}, 0);

        // Randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            cp = (seg == 7) ? 3 : $urandom_range(20, 95);
            rp = $urandom_range(5, 100);
            for (int i = 0; i < 400; i++) begin
                c  = ($urandom_range(99) < cp);
                pc = ($urandom_range(9) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_exp;
                if (m_state == 0 && $urandom_range(15) == 0) pc = 32'h0;
                pre = ($urandom_range(4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
                r  = ($urandom_range(99) < rp);
                rs = ($urandom_range(299) != 0);
                step(c, pc, pre, r, rs);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
